// File: rtl/regfile_arbiter_if.sv
// Requester and register-file bus for regfile_arbiter.
// slave  : the arbiter's view.
// master : the environment's view (both requesters plus the register file).
interface regfile_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int AddrW = 3
);
  logic             A_Req;
  logic             B_Req;
  logic             A_Wr;
  logic             B_Wr;
  logic [AddrW-1:0] A_Addr;
  logic [AddrW-1:0] B_Addr;
  logic [WIDTH-1:0] A_WrData;
  logic [WIDTH-1:0] B_WrData;
  logic             A_Ack;
  logic             B_Ack;
  logic [WIDTH-1:0] A_RdData;
  logic [WIDTH-1:0] B_RdData;
  logic             RF_WrEn;
  logic             RF_RdEn;
  logic [AddrW-1:0] RF_Address;
  logic [WIDTH-1:0] RF_WrData;
  logic [WIDTH-1:0] RF_RdData;

  modport slave (
    input  A_Req, B_Req, A_Wr, B_Wr, A_Addr, B_Addr, A_WrData, B_WrData, RF_RdData,
    output A_Ack, B_Ack, A_RdData, B_RdData, RF_WrEn, RF_RdEn, RF_Address, RF_WrData
  );

  modport master (
    output A_Req, B_Req, A_Wr, B_Wr, A_Addr, B_Addr, A_WrData, B_WrData, RF_RdData,
    input  A_Ack, B_Ack, A_RdData, B_RdData, RF_WrEn, RF_RdEn, RF_Address, RF_WrData
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a single-port register file.
// Each access takes IDLE -> ACCESS -> CAPTURE; the Ack pulse and read data
// appear in the IDLE cycle that follows, during which the acked port is
// not eligible for a new grant.
// Optional feature: define REGARB_FIXED_PRIO_EN for fixed priority (A wins
// ties, no round-robin pointer); otherwise ties are resolved round-robin.
module regfile_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AddrW = 3
) (
  input  logic               CLK,
  input  logic               RST,
  regfile_arbiter_if.slave   bus
);

  localparam int AddrSpan = 1 << AddrW;

  if (DEPTH > AddrSpan) begin : gDepthTooLarge
    $error("regfile_arbiter: DEPTH exceeds the range of AddrW");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } arbStateT;

  arbStateT         state;
  arbStateT         nextState;

  logic             eligA;
  logic             eligB;
  logic             grantB;
  logic             latchGrant;
  logic             finishAccess;
  logic             rfWrEn;
  logic             rfRdEn;

  logic             latB;
  logic             latWr;
  logic [AddrW-1:0] latAddr;
  logic [WIDTH-1:0] latData;
  logic             ackA;
  logic             ackB;
  logic [WIDTH-1:0] rdA;
  logic [WIDTH-1:0] rdB;

`ifndef REGARB_FIXED_PRIO_EN
  logic             lastB;
`endif

  // Eligibility and winner selection among the current requests.
  always_comb begin
    eligA = bus.A_Req & ~ackA;
    eligB = bus.B_Req & ~ackB;
`ifdef REGARB_FIXED_PRIO_EN
    grantB = eligB & ~eligA;
`else
    grantB = eligB & (~eligA | ~lastB);
`endif
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and register-file strobes.
  always_comb begin
    nextState    = state;
    latchGrant   = 1'b0;
    finishAccess = 1'b0;
    rfWrEn       = 1'b0;
    rfRdEn       = 1'b0;
    case (state)
      IDLE: begin
        if (eligA | eligB) begin
          latchGrant = 1'b1;
          nextState  = ACCESS;
        end
      end
      ACCESS: begin
        rfWrEn    = latWr;
        rfRdEn    = ~latWr;
        nextState = CAPTURE;
      end
      CAPTURE: begin
        finishAccess = 1'b1;
        nextState    = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Latched request, completion pulses and per-port read registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      latB    <= 1'b0;
      latWr   <= 1'b0;
      latAddr <= '0;
      latData <= '0;
      ackA    <= 1'b0;
      ackB    <= 1'b0;
      rdA     <= '0;
      rdB     <= '0;
    end else begin
      ackA <= finishAccess & ~latB;
      ackB <= finishAccess & latB;
      if (latchGrant) begin
        latB    <= grantB;
        latWr   <= grantB ? bus.B_Wr     : bus.A_Wr;
        latAddr <= grantB ? bus.B_Addr   : bus.A_Addr;
        latData <= grantB ? bus.B_WrData : bus.A_WrData;
      end
      if (finishAccess && !latWr) begin
        if (latB) begin
          rdB <= bus.RF_RdData;
        end else begin
          rdA <= bus.RF_RdData;
        end
      end
    end
  end

`ifndef REGARB_FIXED_PRIO_EN
  // Round-robin pointer: remembers the most recently granted port.
  // Resets to B so that A wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lastB <= 1'b1;
    end else if (latchGrant) begin
      lastB <= grantB;
    end
  end
`endif

  assign bus.A_Ack      = ackA;
  assign bus.B_Ack      = ackB;
  assign bus.A_RdData   = rdA;
  assign bus.B_RdData   = rdB;
  assign bus.RF_WrEn    = rfWrEn;
  assign bus.RF_RdEn    = rfRdEn;
  assign bus.RF_Address = latAddr;
  assign bus.RF_WrData  = latData;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: a register-file model, a
// transaction-level reference that is compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_regfile_arbiter;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AddrW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.WIDTH(WIDTH), .AddrW(AddrW)) bus ();

  regfile_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AddrW(AddrW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file: write on the enable edge, read data valid the next cycle.
  logic [WIDTH-1:0] rfMem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (rst) begin
      bus.RF_RdData <= '0;
    end else begin
      if (bus.RF_WrEn === 1'b1) rfMem[bus.RF_Address] <= bus.RF_WrData;
      if (bus.RF_RdEn === 1'b1) bus.RF_RdData <= rfMem[bus.RF_Address];
    end
  end

  // Reference model: each access is a pending transaction that completes
  // a fixed number of edges after its grant.
  int               phase = 0;          // edges elapsed since grant, 0 = free
  bit               started = 1'b0;
  bit               mB, mWr, mLastB, mAckA, mAckB;
  logic [AddrW-1:0] mAddr;
  logic [WIDTH-1:0] mData, mRead, mRdA, mRdB;
  logic [WIDTH-1:0] mMem [DEPTH] = '{default: '0};
  int               cntA = 0, cntB = 0, cntRf = 0;

  always @(posedge clk) begin
    bit eA, eB, pB, nA, nB;
    if (rst) begin
      phase = 0; mAckA = 0; mAckB = 0; mRdA = '0; mRdB = '0;
      mAddr = '0; mData = '0; mWr = 0; mB = 0; mLastB = 1; started = 1;
    end else begin
      nA = 0; nB = 0;
      if (phase == 0) begin
        eA = bus.A_Req && !mAckA;
        eB = bus.B_Req && !mAckB;
        if (eA || eB) begin
`ifdef REGARB_FIXED_PRIO_EN
          pB = !eA;
`else
          pB = !eA || (eB && !mLastB);
`endif
          mB = pB; mLastB = pB;
          mWr   = pB ? bus.B_Wr     : bus.A_Wr;
          mAddr = pB ? bus.B_Addr   : bus.A_Addr;
          mData = pB ? bus.B_WrData : bus.A_WrData;
          phase = 1;
        end
      end else if (phase == 1) begin
        mRead = mMem[mAddr];
        if (mWr) mMem[mAddr] = mData;
        phase = 2;
      end else begin
        if (mB) nB = 1; else nA = 1;
        if (!mWr) begin
          if (mB) mRdB = mRead; else mRdA = mRead;
        end
        phase = 0;
      end
      mAckA = nA; mAckB = nB;
    end
    #1;
    if (started) begin
      check("A_Ack", bus.A_Ack, mAckA);
      check("B_Ack", bus.B_Ack, mAckB);
      check("A_RdData", bus.A_RdData, mRdA);
      check("B_RdData", bus.B_RdData, mRdB);
      check("RF_WrEn", bus.RF_WrEn, (phase == 1) && mWr);
      check("RF_RdEn", bus.RF_RdEn, (phase == 1) && !mWr);
      check("RF_Address", bus.RF_Address, mAddr);
      check("RF_WrData", bus.RF_WrData, mData);
      check("ackExclusive", bus.A_Ack & bus.B_Ack, 0);
      if (bus.A_Ack === 1'b1) cntA++;
      if (bus.B_Ack === 1'b1) cntB++;
      if (bus.RF_WrEn === 1'b1 || bus.RF_RdEn === 1'b1) cntRf++;
    end
  end

  task automatic request(input bit isB, input bit wr, input logic [AddrW-1:0] addr,
                         input logic [WIDTH-1:0] data);
    if (isB) begin
      bus.B_Req = 1; bus.B_Wr = wr; bus.B_Addr = addr; bus.B_WrData = data;
    end else begin
      bus.A_Req = 1; bus.A_Wr = wr; bus.A_Addr = addr; bus.A_WrData = data;
    end
  endtask

  // Wait (bounded) for an Ack on the given port; returns edges waited.
  task automatic waitAck(input bit isB, output int edges);
    bit ok = 0;
    edges = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      edges = i + 1;
      if ((isB ? bus.B_Ack : bus.A_Ack) === 1'b1) begin ok = 1; break; end
    end
    check(isB ? "B_Ack arrives" : "A_Ack arrives", ok, 1);
  endtask

  // Both ports request on the same edge; check who is served first.
  task automatic pairRound(input bit expFirstB, input bit aWr, input logic [AddrW-1:0] aAddr,
                           input logic [WIDTH-1:0] aData, input logic [AddrW-1:0] bAddr);
    bit ok = 0, firstB = 0;
    int e;
    @(negedge clk);
    request(0, aWr, aAddr, aData);
    request(1, 0, bAddr, '0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (bus.A_Ack === 1'b1 || bus.B_Ack === 1'b1) begin
        ok = 1; firstB = bus.B_Ack; break;
      end
    end
    check("pair first ack", ok, 1);
    check("pair first port", firstB, expFirstB);
    @(negedge clk);
    if (firstB) bus.B_Req = 0; else bus.A_Req = 0;
    waitAck(!firstB, e);
    @(negedge clk);
    bus.A_Req = 0; bus.B_Req = 0;
  endtask

  initial begin
    int e, a0, rf0;
    bit expFirstB;
    logic [WIDTH-1:0] expB;
    rst = 1;
    bus.A_Req = 0; bus.B_Req = 0; bus.A_Wr = 0; bus.B_Wr = 0;
    bus.A_Addr = '0; bus.B_Addr = '0; bus.A_WrData = '0; bus.B_WrData = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset A_Ack", bus.A_Ack, 0);
    check("reset RF_WrEn", bus.RF_WrEn, 0);
    check("reset A_RdData", bus.A_RdData, 0);
    @(negedge clk) rst = 0;

    // A writes 15 to address 0.
    @(negedge clk);
    request(0, 1, 0, 15);
    @(posedge clk); #2;
    check("write RF_WrEn", bus.RF_WrEn, 1);
    check("write RF_Address", bus.RF_Address, 0);
    check("write RF_WrData", bus.RF_WrData, 15);
    waitAck(0, e);
    check("grant to A_Ack edges", e + 1, 3);
    @(negedge clk) bus.A_Req = 0;

    // A reads address 0 back.
    @(negedge clk);
    request(0, 0, 0, 0);
    @(posedge clk); #2;
    check("read RF_RdEn", bus.RF_RdEn, 1);
    waitAck(0, e);
    check("read A_RdData", bus.A_RdData, 15);
    check("read B_RdData untouched", bus.B_RdData, 0);
    @(negedge clk) bus.A_Req = 0;

    // Tie after reset: A wins, B then reads what A wrote.
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    pairRound(0, 1, 5, 39, 5);
    check("pair1 B_RdData", bus.B_RdData, 39);

    // A alone, then another tie.
    @(negedge clk);
    request(0, 0, 0, 0);
    waitAck(0, e);
    @(negedge clk) bus.A_Req = 0;
`ifdef REGARB_FIXED_PRIO_EN
    expFirstB = 0; expB = 77;
`else
    expFirstB = 1; expB = 39;
`endif
    pairRound(expFirstB, 1, 5, 77, 5);
    check("pair2 B_RdData", bus.B_RdData, expB);
    repeat (2) pairRound(expFirstB, 0, 1, 0, 5);

    // Reset while a B read is in CAPTURE aborts it.
    repeat (3) @(negedge clk);
    request(1, 0, 5, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #2;
    check("abort B_Ack", bus.B_Ack, 0);
    check("abort B_RdData", bus.B_RdData, 0);
    check("abort RF_RdEn", bus.RF_RdEn, 0);
    check("abort RF_WrEn", bus.RF_WrEn, 0);
    @(negedge clk);
    rst = 0; bus.B_Req = 0;
    @(posedge clk); #2;
    check("abort no late B_Ack", bus.B_Ack, 0);

    // Req held past Ack: one Ack, one register-file access.
    @(negedge clk);
    a0 = cntA; rf0 = cntRf;
    request(0, 1, 2, 16'h55);
    waitAck(0, e);
    @(negedge clk);
    @(negedge clk) bus.A_Req = 0;
    repeat (6) @(posedge clk);
    #2;
    check("held Req ack count", cntA - a0, 1);
    check("held Req RF accesses", cntRf - rf0, 1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      if (!bus.A_Req) begin
        if ($urandom_range(0, 2) == 0)
          request(0, $urandom_range(0, 1), AddrW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
      end else if (bus.A_Ack === 1'b1 && $urandom_range(0, 3) != 0) begin
        bus.A_Req = 0;
      end else if ($urandom_range(0, 4) == 0) begin
        bus.A_Addr = AddrW'($urandom_range(0, DEPTH - 1)); bus.A_WrData = WIDTH'($urandom);
      end
      if (!bus.B_Req) begin
        if ($urandom_range(0, 2) == 0)
          request(1, $urandom_range(0, 1), AddrW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
      end else if (bus.B_Ack === 1'b1 && $urandom_range(0, 3) != 0) begin
        bus.B_Req = 0;
      end else if ($urandom_range(0, 4) == 0) begin
        bus.B_Wr = $urandom_range(0, 1); bus.B_WrData = WIDTH'($urandom);
      end
    end
    @(negedge clk);
    rst = 0; bus.A_Req = 0; bus.B_Req = 0;
    repeat (5) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
